// File: rtl/fp16_align_stage.sv
// fp16_align_stage
//   Registered pre-alignment stage that sits directly in front of the FP16
//   adder core. Each accepted A/B pair is classified, ordered by magnitude and
//   the smaller mantissa is right-aligned with guard/round/sticky bits.
//   Special cases are resolved here, so the adder core only ever has to deal
//   with finite operands. A main + skid output buffer lets in_ready come
//   straight from a flop.
//
// Ports
//   clk, rst           rising-edge clock, synchronous active-high reset
//   in_valid/in_ready  input handshake for the A/B pair
//   A, B               FP16 operands
//   out_valid/out_ready output handshake for the aligned bundle
//   out_sign_big       sign of the larger-magnitude operand
//   out_eff_sub        operand signs differ
//   out_exp            effective exponent of the larger operand
//   out_man_big        {hidden, mantissa, GRS zeros} of the larger operand
//   out_man_small      aligned smaller mantissa, sticky folded into the LSB
//   out_special        00 normal, 01 zero, 10 inf, 11 NaN
//   out_special_val    final FP16 result when out_special != 00, else 0
module fp16_align_stage #(
  parameter int GRS_BITS      = 3,
  parameter bit FLUSH_SUBNORM = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [15:0]            A,
  input  logic [15:0]            B,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_sign_big,
  output logic                   out_eff_sub,
  output logic [4:0]             out_exp,
  output logic [11+GRS_BITS-1:0] out_man_big,
  output logic [11+GRS_BITS-1:0] out_man_small,
  output logic [1:0]             out_special,
  output logic [15:0]            out_special_val
);

  localparam int MW = 11 + GRS_BITS;

  typedef enum logic [1:0] {
    SP_NORMAL = 2'b00,
    SP_ZERO   = 2'b01,
    SP_INF    = 2'b10,
    SP_NAN    = 2'b11
  } special_t;

  // Decoded operand: effective exponent and {hidden, mantissa}.
  typedef struct packed {
    logic        sign;
    logic        is_nan;
    logic        is_inf;
    logic        is_zero;
    logic [4:0]  exp;
    logic [10:0] man;
  } op_t;

  typedef struct packed {
    logic          sign_big;
    logic          eff_sub;
    logic [4:0]    exp;
    logic [MW-1:0] man_big;
    logic [MW-1:0] man_small;
    special_t      special;
    logic [15:0]   special_val;
  } bundle_t;

  function automatic op_t classify(input logic [15:0] x);
    op_t        o;
    logic [4:0] e;
    logic [9:0] m;
    e      = x[14:10];
    m      = x[9:0];
    o      = '0;
    o.sign = x[15];
    if (e == 5'd31) begin
      o.is_nan = (m != 10'd0);
      o.is_inf = (m == 10'd0);
      o.exp    = e;
      o.man    = {1'b0, m};
    end else if (e == 5'd0) begin
      if (m == 10'd0 || FLUSH_SUBNORM) begin
        // Zero (or flushed subnormal) keeps exponent 0 so it always orders
        // below any nonzero operand and aligns to nothing.
        o.is_zero = 1'b1;
        o.exp     = 5'd0;
        o.man     = 11'd0;
      end else begin
        o.exp = 5'd1;
        o.man = {1'b0, m};
      end
    end else begin
      o.exp = e;
      o.man = {1'b1, m};
    end
    return o;
  endfunction

  // ---------------------------------------------------------------------------
  // Combinational datapath for the incoming pair
  // ---------------------------------------------------------------------------
  op_t           op_a, op_b, op_big, op_small;
  logic          b_big;
  logic [4:0]    d;
  logic [MW-1:0] small_full, shifted, lost_mask;
  bundle_t       new_bundle;

  // NOTE: every always_comb output gets a default first, so no path can leave
  // a variable unassigned and infer a latch.
  always_comb begin
    new_bundle = '0;
    shifted    = '0;
    lost_mask  = '0;

    op_a  = classify(A);
    op_b  = classify(B);
    // Strictly greater: on a magnitude tie A stays the big operand.
    b_big    = {op_b.exp, op_b.man} > {op_a.exp, op_a.man};
    op_big   = b_big ? op_b : op_a;
    op_small = b_big ? op_a : op_b;

    d          = op_big.exp - op_small.exp;
    small_full = {op_small.man, {GRS_BITS{1'b0}}};

    new_bundle.sign_big = op_big.sign;
    new_bundle.eff_sub  = op_a.sign ^ op_b.sign;
    new_bundle.exp      = op_big.exp;
    new_bundle.man_big  = {op_big.man, {GRS_BITS{1'b0}}};

    if (int'(d) >= MW) begin
      // Everything shifts out; only the sticky survives.
      new_bundle.man_small = {{(MW-1){1'b0}}, |small_full};
    end else begin
      shifted   = small_full >> d;
      lost_mask = ~({MW{1'b1}} << d);
      new_bundle.man_small = shifted | {{(MW-1){1'b0}}, |(small_full & lost_mask)};
    end

    if (op_a.is_nan || op_b.is_nan ||
        (op_a.is_inf && op_b.is_inf && (op_a.sign != op_b.sign))) begin
      new_bundle.special     = SP_NAN;
      new_bundle.special_val = 16'h7E00;
    end else if (op_a.is_inf || op_b.is_inf) begin
      new_bundle.special     = SP_INF;
      new_bundle.special_val = {(op_a.is_inf ? op_a.sign : op_b.sign), 15'h7C00};
    end else if (op_a.is_zero && op_b.is_zero) begin
      new_bundle.special     = SP_ZERO;
      new_bundle.special_val = {op_a.sign & op_b.sign, 15'h0000};
    end else begin
      new_bundle.special     = SP_NORMAL;
      new_bundle.special_val = 16'h0000;
    end
  end

  // ---------------------------------------------------------------------------
  // Main + skid output buffer
  // ---------------------------------------------------------------------------
  bundle_t main_q, skid_q;
  logic    main_valid_q, skid_valid_q, ready_q;
  logic    accept, consume;
  logic    main_valid_d, skid_valid_d;
  logic    load_main_new, load_main_skid, load_skid;

  always_comb begin
    accept         = in_valid & ready_q;
    consume        = main_valid_q & out_ready;
    main_valid_d   = main_valid_q;
    skid_valid_d   = skid_valid_q;
    load_main_new  = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;

    if (consume) begin
      if (skid_valid_q) begin
        // ready_q is low whenever skid is full, so no accept can coincide.
        load_main_skid = 1'b1;
        skid_valid_d   = 1'b0;
      end else if (accept) begin
        load_main_new = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (!main_valid_q) begin
        load_main_new = 1'b1;
        main_valid_d  = 1'b1;
      end else begin
        load_skid    = 1'b1;
        skid_valid_d = 1'b1;
      end
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      ready_q      <= 1'b0;
      // NOTE: the data registers are reset too, because the outputs are
      // required to read 0 while the stage is held in reset.
      main_q       <= '0;
      skid_q       <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      ready_q      <= !skid_valid_d;
      if (load_main_new)       main_q <= new_bundle;
      else if (load_main_skid) main_q <= skid_q;
      if (load_skid)           skid_q <= new_bundle;
    end
  end

  assign in_ready        = ready_q;
  assign out_valid       = main_valid_q;
  assign out_sign_big    = main_q.sign_big;
  assign out_eff_sub     = main_q.eff_sub;
  assign out_exp         = main_q.exp;
  assign out_man_big     = main_q.man_big;
  assign out_man_small   = main_q.man_small;
  assign out_special     = main_q.special;
  assign out_special_val = main_q.special_val;

endmodule

// File: tb/tb_fp16_align_stage.sv
// tb_fp16_align_stage
//   Directed-vector bench for fp16_align_stage. Two instances share the same
//   inputs: one with default parameters and one with subnormal flushing.
module tb_fp16_align_stage;

  localparam int MW = 14;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          out_ready;
  logic [15:0]   A, B;

  logic          in_ready, out_valid, out_sign_big, out_eff_sub;
  logic [4:0]    out_exp;
  logic [MW-1:0] out_man_big, out_man_small;
  logic [1:0]    out_special;
  logic [15:0]   out_special_val;

  logic          in_ready_f, out_valid_f, out_sign_big_f, out_eff_sub_f;
  logic [4:0]    out_exp_f;
  logic [MW-1:0] out_man_big_f, out_man_small_f;
  logic [1:0]    out_special_f;
  logic [15:0]   out_special_val_f;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fp16_align_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
    .out_sign_big(out_sign_big), .out_eff_sub(out_eff_sub), .out_exp(out_exp),
    .out_man_big(out_man_big), .out_man_small(out_man_small),
    .out_special(out_special), .out_special_val(out_special_val)
  );

  fp16_align_stage #(.GRS_BITS(3), .FLUSH_SUBNORM(1'b1)) dut_f (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_f),
    .A(A), .B(B), .out_valid(out_valid_f), .out_ready(out_ready),
    .out_sign_big(out_sign_big_f), .out_eff_sub(out_eff_sub_f), .out_exp(out_exp_f),
    .out_man_big(out_man_big_f), .out_man_small(out_man_small_f),
    .out_special(out_special_f), .out_special_val(out_special_val_f)
  );

  // Whole output bundle: sign_big, eff_sub, exp, man_big, man_small, special, special_val.
  wire [52:0] got   = {out_sign_big, out_eff_sub, out_exp, out_man_big, out_man_small,
                       out_special, out_special_val};
  wire [52:0] got_f = {out_sign_big_f, out_eff_sub_f, out_exp_f, out_man_big_f,
                       out_man_small_f, out_special_f, out_special_val_f};

  // Present one pair with out_ready=1 and return once it has been accepted,
  // leaving the sample point 1 ns after the accepting edge.
  task automatic send(input logic [15:0] a, input logic [15:0] b, output bit ok);
    ok = 1'b0;
    @(negedge clk);
    A = a; B = b; in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (in_ready) ok = 1'b1;
      @(posedge clk);
    end
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; A = 16'h0; B = 16'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_valid_f !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid: got %b/%b expected 0", out_valid, out_valid_f);
    end
    checks++;
    if (in_ready !== 1'b0 || in_ready_f !== 1'b0) begin
      errors++; $display("FAIL reset_in_ready: got %b/%b expected 0", in_ready, in_ready_f);
    end
    checks++;
    if (got !== 53'd0 || got_f !== 53'd0) begin
      errors++; $display("FAIL reset_data: got %h/%h expected 0", got, got_f);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || in_ready_f !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: in_ready %b/%b out_valid %b expected 1/1/0",
               in_ready, in_ready_f, out_valid);
    end
  endtask

  task automatic test_align();
    logic [15:0]   va   [8];
    logic [15:0]   vb   [8];
    logic [52:0]   want [8];
    logic [MW-1:0] f_small [8];
    logic [1:0]    f_sp [8];
    logic [15:0]   f_val [8];
    bit ok;
    va = '{16'h3C00, 16'h3C00, 16'h3C00, 16'h4000, 16'h4000, 16'h3C00, 16'h0001, 16'h0000};
    vb = '{16'h3C00, 16'h4000, 16'hB800, 16'h0001, 16'h3001, 16'hC000, 16'h0002, 16'h3C00};
    //             sb    es    exp     man_big    man_small  sp     val
    want = '{{1'b0, 1'b0, 5'd15, 14'h2000, 14'h2000, 2'b00, 16'h0000},
             {1'b0, 1'b0, 5'd16, 14'h2000, 14'h1000, 2'b00, 16'h0000},
             {1'b0, 1'b1, 5'd15, 14'h2000, 14'h1000, 2'b00, 16'h0000},
             {1'b0, 1'b0, 5'd16, 14'h2000, 14'h0001, 2'b00, 16'h0000},
             {1'b0, 1'b0, 5'd16, 14'h2000, 14'h0201, 2'b00, 16'h0000},
             {1'b1, 1'b1, 5'd16, 14'h2000, 14'h1000, 2'b00, 16'h0000},
             {1'b0, 1'b0, 5'd1,  14'h0010, 14'h0008, 2'b00, 16'h0000},
             {1'b0, 1'b0, 5'd15, 14'h2000, 14'h0000, 2'b00, 16'h0000}};
    f_small = '{14'h2000, 14'h1000, 14'h1000, 14'h0000, 14'h0201, 14'h1000, 14'h0000, 14'h0000};
    f_sp    = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00};
    f_val   = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    for (int i = 0; i < 8; i++) begin
      send(va[i], vb[i], ok);
      checks++;
      if (!ok || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL align_valid[%0d]: accepted %b out_valid %b expected 1/1", i, ok, out_valid);
      end
      checks++;
      if (got !== want[i]) begin
        errors++;
        $display("FAIL align[%0d] %h+%h: got %h expected %h", i, va[i], vb[i], got, want[i]);
      end
      checks++;
      if ({out_man_small_f, out_special_f, out_special_val_f} !== {f_small[i], f_sp[i], f_val[i]}) begin
        errors++;
        $display("FAIL flush[%0d] %h+%h: got small %h sp %b val %h expected %h %b %h", i,
                 va[i], vb[i], out_man_small_f, out_special_f, out_special_val_f,
                 f_small[i], f_sp[i], f_val[i]);
      end
    end
    idle(2);
  endtask

  task automatic test_special();
    logic [15:0] va [7];
    logic [15:0] vb [7];
    logic [17:0] want [7];
    bit ok;
    va   = '{16'h7C01, 16'h7C00, 16'hFC00, 16'h8000, 16'h7C00, 16'h0000, 16'h3C00};
    vb   = '{16'h3C00, 16'hFC00, 16'h3C00, 16'h8000, 16'h7C00, 16'h8000, 16'h7E00};
    want = '{{2'b11, 16'h7E00}, {2'b11, 16'h7E00}, {2'b10, 16'hFC00}, {2'b01, 16'h8000},
             {2'b10, 16'h7C00}, {2'b01, 16'h0000}, {2'b11, 16'h7E00}};
    for (int i = 0; i < 7; i++) begin
      send(va[i], vb[i], ok);
      checks++;
      if (!ok || out_valid !== 1'b1 || {out_special, out_special_val} !== want[i]) begin
        errors++;
        $display("FAIL special[%0d] %h+%h: got valid %b sp %b val %h expected 1 %b %h", i,
                 va[i], vb[i], out_valid, out_special, out_special_val, want[i][17:16],
                 want[i][15:0]);
      end
    end
    idle(2);
  endtask

  // Streams four pairs (exp 15..18, B=0) with out_ready held low for the
  // first stall_cycles cycles and checks order, hold and throughput.
  task automatic test_stream(input int stall_cycles);
    int sent = 0;
    int rcvd = 0;
    int done_c = -1;
    for (int c = 0; c < 30 && rcvd < 4; c++) begin
      @(negedge clk);
      out_ready = (c >= stall_cycles);
      in_valid  = (sent < 4);
      A = 16'h3C00 + 16'(sent << 10);
      B = 16'h0000;
      #1;
      if (stall_cycles > 0 && c == stall_cycles - 1) begin
        checks++;
        if (in_ready !== 1'b0) begin
          errors++; $display("FAIL skid_full_in_ready: got %b expected 0", in_ready);
        end
        checks++;
        if (out_valid !== 1'b1 || out_exp !== 5'd15) begin
          errors++;
          $display("FAIL stall_hold: got valid %b exp %0d expected 1 15", out_valid, out_exp);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (out_exp !== 5'(15 + rcvd) || out_man_big !== 14'h2000 || out_man_small !== 14'h0000) begin
          errors++;
          $display("FAIL stream_order[%0d]: got exp %0d big %h small %h expected %0d 2000 0000",
                   rcvd, out_exp, out_man_big, out_man_small, 15 + rcvd);
        end
        rcvd++;
        if (rcvd == 4) done_c = c;
      end
      if (in_valid && in_ready) sent++;
    end
    checks++;
    if (rcvd != 4) begin
      errors++; $display("FAIL stream_count: got %0d expected 4", rcvd);
    end
    if (stall_cycles == 0) begin
      checks++;
      if (done_c != 4) begin
        errors++; $display("FAIL stream_rate: last output in cycle %0d expected 4", done_c);
      end
    end
    idle(3);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL stream_drain: got valid %b in_ready %b expected 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    test_stream(0);
  endtask

  task automatic test_stall();
    test_stream(3);
  endtask

  task automatic test_stall_reset();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      out_ready = 1'b0; in_valid = 1'b1;
      A = 16'h4400 + 16'(i << 10); B = 16'h3C00;
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL pre_reset_full: got valid %b in_ready %b expected 1 0", out_valid, in_ready);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || got !== 53'd0) begin
      errors++;
      $display("FAIL mid_reset: got valid %b in_ready %b data %h expected 0 0 0",
               out_valid, in_ready, got);
    end
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL post_reset: got valid %b in_ready %b expected 0 1", out_valid, in_ready);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL post_reset_stale: got valid %b expected 0", out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_align();
    test_special();
    test_back_to_back();
    test_stall();
    test_stall_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
